// File: rtl/hscale_pkg.sv
// Shared encodings and helpers for the horizontal bilinear scaler.
// Build option HSCALE_ROUND_EN selects round-half-up instead of truncation.
`ifndef HSCALE_STEP_W
`define HSCALE_STEP_W(iw, fw) ((iw) + (fw))
`endif

package hscale_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_PRIME = 4'b0010,
    ST_RUN   = 4'b0100,
    ST_DRAIN = 4'b1000
  } state_t;

`ifdef HSCALE_ROUND_EN
  localparam bit ROUND_EN = 1'b1;
`else
  localparam bit ROUND_EN = 1'b0;
`endif

  // Half an LSB of the output in phase units, or zero when truncating.
  function automatic int unsigned hscale_round_k(input int unsigned frac_w);
    return ROUND_EN ? (32'd1 << (frac_w - 32'd1)) : 32'd0;
  endfunction

endpackage

// File: rtl/hscale_lerp.sv
// One channel of the interpolation datapath: stage 1 registers the two
// weighted products, stage 2 registers the rounded/truncated sum.
module hscale_lerp
  import hscale_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int FRAC_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_stall,
  input  logic [DATA_W-1:0] i_l,
  input  logic [DATA_W-1:0] i_r,
  input  logic [FRAC_W-1:0] i_frac,
  output logic [DATA_W-1:0] o_pix
);

  localparam int MW = DATA_W + FRAC_W + 1;
  localparam logic [MW-1:0] ROUND_K = MW'(hscale_round_k(FRAC_W));

  logic [MW-1:0] w_one;
  logic [MW-1:0] w_wl;
  logic [MW-1:0] w_wr;
  logic [MW-1:0] w_lx;
  logic [MW-1:0] w_rx;
  logic [MW-1:0] w_sum;
  logic [MW-1:0] r_pl;
  logic [MW-1:0] r_pr;
  logic [DATA_W-1:0] r_pix;

  // Weights are (2^FRAC_W - f) and f; with f = 0 the right product is zero.
  assign w_one = MW'(1) << FRAC_W;
  assign w_wr  = MW'(i_frac);
  assign w_wl  = w_one - w_wr;
  assign w_lx  = MW'(i_l);
  assign w_rx  = MW'(i_r);
  assign w_sum = r_pl + r_pr + ROUND_K;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pl  <= '0;
      r_pr  <= '0;
      r_pix <= '0;
    end else if (!i_stall) begin
      r_pl  <= w_lx * w_wl;
      r_pr  <= w_rx * w_wr;
      r_pix <= DATA_W'(w_sum >> FRAC_W);
    end
  end

  assign o_pix = r_pix;

endmodule

// File: rtl/hscale_lerp_stream.sv
// Streaming horizontal bilinear scaler: one source line in, cfg_tgt_width
// interpolated pixels out. Build option HSCALE_ROUND_EN enables rounding.
module hscale_lerp_stream
  import hscale_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int CH      = 3,
  parameter int FRAC_W  = 8,
  parameter int INT_W   = 4,
  parameter int WIDTH_W = 11
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [CH*DATA_W-1:0]                   in_data,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic                                   in_eol,
  output logic [CH*DATA_W-1:0]                   out_data,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic                                   out_eol,
  input  logic [WIDTH_W-1:0]                     cfg_src_width,
  input  logic [WIDTH_W-1:0]                     cfg_tgt_width,
  input  logic [`HSCALE_STEP_W(INT_W, FRAC_W)-1:0] cfg_step,
  output logic                                   busy,
  output logic                                   err_eol
);

  localparam int PW  = CH * DATA_W;
  localparam int SW  = `HSCALE_STEP_W(INT_W, FRAC_W);
  localparam int AW  = INT_W + 1;
  localparam int PHW = AW + FRAC_W;

  state_t r_state;
  state_t w_state_next;

  logic [PW-1:0]      r_l;
  logic [PW-1:0]      r_r;
  logic [PW-1:0]      w_pix;
  logic [FRAC_W-1:0]  r_frac;
  logic [AW-1:0]      r_adv;
  logic [WIDTH_W-1:0] r_src_w;
  logic [WIDTH_W-1:0] r_tgt_w;
  logic [WIDTH_W-1:0] r_in_cnt;
  logic [WIDTH_W-1:0] r_out_cnt;
  logic [SW-1:0]      r_step;
  logic               r_exh;
  logic               r_err_eol;
  logic               r_busy;
  logic               r_v1;
  logic               r_eol1;
  logic               r_v2;
  logic               r_eol2;

  logic               w_stall;
  logic               w_issue;
  logic               w_shift;
  logic               w_acc;
  logic               w_in_rdy;
  logic               w_last_in;
  logic               w_last_out;
  logic [WIDTH_W-1:0] w_cnt_nx;
  logic [WIDTH_W-1:0] w_src_w;
  logic [PHW-1:0]     w_phase;

  // A held output freezes the whole pipeline and the issue logic.
  assign w_stall    = r_v2 && !out_ready;
  assign w_acc      = in_valid && in_ready;
  assign w_src_w    = (r_state == ST_IDLE) ? cfg_src_width : r_src_w;
  assign w_cnt_nx   = ((r_state == ST_IDLE) ? '0 : r_in_cnt) + WIDTH_W'(1);
  assign w_last_in  = (w_cnt_nx == w_src_w);
  assign w_last_out = ((r_out_cnt + WIDTH_W'(1)) == r_tgt_w);
  assign w_phase    = PHW'(r_frac) + PHW'(r_step);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_in_rdy     = 1'b0;
    w_issue      = 1'b0;
    w_shift      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_in_rdy = 1'b1;
        if (in_valid) w_state_next = ST_PRIME;
      end
      ST_PRIME: begin
        w_in_rdy = !r_exh;
        if (r_exh || in_valid) w_state_next = ST_RUN;
      end
      ST_RUN: begin
        if (r_adv != '0) begin
          w_in_rdy = !r_exh;
          w_shift  = r_exh || in_valid;
        end else if (!w_stall) begin
          w_issue = 1'b1;
          if (w_last_out) w_state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Swallow the rest of the source line, then wait for the pipeline.
        w_in_rdy = !r_exh;
        if (r_exh && !r_v1 && !r_v2) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign in_ready = w_in_rdy && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_l       <= '0;
      r_r       <= '0;
      r_frac    <= '0;
      r_adv     <= '0;
      r_src_w   <= '0;
      r_tgt_w   <= '0;
      r_step    <= '0;
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
      r_exh     <= 1'b0;
      r_err_eol <= 1'b0;
      r_busy    <= 1'b0;
      r_v1      <= 1'b0;
      r_eol1    <= 1'b0;
      r_v2      <= 1'b0;
      r_eol2    <= 1'b0;
    end else begin
      if (w_acc) begin
        r_in_cnt <= w_cnt_nx;
        r_exh    <= w_last_in || in_eol;
        if (in_eol != w_last_in) r_err_eol <= 1'b1;
      end
      if (r_state == ST_IDLE && in_valid) begin
        r_src_w   <= cfg_src_width;
        r_tgt_w   <= cfg_tgt_width;
        r_step    <= cfg_step;
        r_l       <= in_data;
        r_r       <= in_data;
        r_frac    <= '0;
        r_adv     <= '0;
        r_out_cnt <= '0;
        r_busy    <= 1'b1;
      end
      if (r_state == ST_PRIME && w_acc) begin
        r_r <= in_data;
      end
      // Once the source is exhausted R keeps its value, replicating the new L.
      if (w_shift) begin
        r_l   <= r_r;
        r_adv <= r_adv - AW'(1);
        if (!r_exh) r_r <= in_data;
      end
      if (w_issue) begin
        {r_adv, r_frac} <= w_phase;
        r_out_cnt       <= r_out_cnt + WIDTH_W'(1);
      end
      if (!w_stall) begin
        r_v1   <= w_issue;
        r_eol1 <= w_issue && w_last_out;
        r_v2   <= r_v1;
        r_eol2 <= r_eol1;
      end
      if (r_v2 && out_ready && r_eol2) begin
        r_busy <= 1'b0;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
      hscale_lerp #(
        .DATA_W(DATA_W),
        .FRAC_W(FRAC_W)
      ) u_lerp (
        .clk    (clk),
        .rst    (rst),
        .i_stall(w_stall),
        .i_l    (r_l[gi*DATA_W +: DATA_W]),
        .i_r    (r_r[gi*DATA_W +: DATA_W]),
        .i_frac (r_frac),
        .o_pix  (w_pix[gi*DATA_W +: DATA_W])
      );
    end
  endgenerate

  assign out_data  = w_pix;
  assign out_valid = r_v2;
  assign out_eol   = r_eol2;
  assign busy      = r_busy;
  assign err_eol   = r_err_eol;

endmodule

// File: tb/tb_hscale_lerp_stream.sv
// Scoreboard bench for hscale_lerp_stream: directed lines with hand-computed
// expected pixels; channels carry offsets 0/17/41 so lane mix-ups show.
module tb_hscale_lerp_stream;

  localparam int DW = 8;
  localparam int CH = 3;
  localparam int FW = 8;
  localparam int IW = 4;
  localparam int WW = 11;
  localparam int PW = DW * CH;

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          in_eol;
  logic [PW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_eol;
  logic [WW-1:0] cfg_src_width;
  logic [WW-1:0] cfg_tgt_width;
  logic [IW+FW-1:0] cfg_step;
  logic          busy;
  logic          err_eol;

  int n_chk = 0;
  int n_err = 0;
  int n_acc = 0;
  logic [PW:0] exp_q[$];
  int g_src[$];
  int g_exp[$];
  bit mon_en  = 1'b0;
  bit bp_mode = 1'b0;

  always #5 clk = ~clk;

  hscale_lerp_stream #(
    .DATA_W(DW), .CH(CH), .FRAC_W(FW), .INT_W(IW), .WIDTH_W(WW)
  ) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .in_eol(in_eol),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_eol(out_eol),
    .cfg_src_width(cfg_src_width), .cfg_tgt_width(cfg_tgt_width), .cfg_step(cfg_step),
    .busy(busy), .err_eol(err_eol)
  );

  function automatic logic [PW-1:0] pack(input int v);
    logic [7:0] c0;
    logic [7:0] c1;
    logic [7:0] c2;
    c0 = 8'(v);
    c1 = 8'(v + 17);
    c2 = 8'(v + 41);
    return {c2, c1, c0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Output monitor: pops the scoreboard on each handshake and checks hold.
  initial begin
    logic [PW:0] e;
    logic [PW:0] held;
    bit held_v;
    held_v = 1'b0;
    held   = '0;
    forever begin
      @(negedge clk);
      if (rst || !mon_en) begin
        held_v = 1'b0;
      end else begin
        if (held_v) chk("stall_hold", 32'({out_valid, out_eol, out_data}), 32'({1'b1, held}));
        if (out_valid && out_ready) begin
          $display("out data=%h eol=%b", out_data, out_eol);
          if (exp_q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL extra_out actual=%h required=none", out_data);
          end else begin
            e = exp_q.pop_front();
            chk("out_pix", 32'({out_eol, out_data}), 32'(e));
          end
        end
        held_v = out_valid && !out_ready;
        held   = {out_eol, out_data};
      end
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = bp_mode ? !out_ready : 1'b1;
    end
  end

  task automatic run_line(input string name, input int step, input int sw, input int tw,
                          input int eol_idx, input bit rnd, input bit exp_err);
    int  i;
    int  t;
    bit  hs;
    @(posedge clk);
    #1;
    cfg_step      = 12'(step);
    cfg_src_width = 11'(sw);
    cfg_tgt_width = 11'(tw);
    for (int k = 0; k < g_exp.size(); k++)
      exp_q.push_back({(k == g_exp.size() - 1), pack(g_exp[k])});
    i = 0;
    t = 0;
    n_acc = 0;
    while (i < g_src.size() && t < 2000) begin
      in_data  = pack(g_src[i]);
      in_eol   = (i == eol_idx);
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      hs = in_valid && in_ready;
      if (hs) $display("in data=%h eol=%b", in_data, in_eol);
      @(posedge clk);
      #1;
      if (hs) begin
        i++;
        n_acc++;
      end
      t++;
    end
    in_valid = 1'b0;
    in_eol   = 1'b0;
    chk({name, "_src_taken"}, 32'(n_acc), 32'(g_src.size()));
    chk({name, "_busy_mid"}, 32'(busy), 32'd1);
    t = 0;
    while ((busy || exp_q.size() != 0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_outs_left"}, 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
    chk({name, "_idle_ready"}, 32'(in_ready), 32'd1);
    chk({name, "_busy_end"}, 32'(busy), 32'd0);
    chk({name, "_err_eol"}, 32'(err_eol), 32'(exp_err));
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({name, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({name, "_out_data"}, 32'(out_data), 32'd0);
    chk({name, "_out_eol"}, 32'(out_eol), 32'd0);
    chk({name, "_busy"}, 32'(busy), 32'd0);
    chk({name, "_err_eol"}, 32'(err_eol), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    in_valid      = 1'b0;
    in_eol        = 1'b0;
    in_data       = '0;
    cfg_src_width = 11'd8;
    cfg_tgt_width = 11'd8;
    cfg_step      = 12'h100;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("por");
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("por_idle_ready", 32'(in_ready), 32'd1);

    g_src = '{0, 1, 2, 3, 4, 5, 6, 7};
    g_exp = '{0, 1, 2, 3, 4, 5, 6, 7};
    run_line("identity", 'h100, 8, 8, 7, 1'b0, 1'b0);

    g_src = '{0, 100, 200, 40};
    g_exp = '{0, 50, 100, 150, 200, 120, 40, 40};
    run_line("up2", 'h080, 4, 8, 3, 1'b0, 1'b0);

    g_src = '{0, 10, 20, 30, 40, 50, 60, 70};
    g_exp = '{0, 20, 40, 60};
    run_line("down2", 'h200, 8, 4, 7, 1'b0, 1'b0);

    bp_mode = 1'b1;
    g_src = '{0, 100, 200, 40};
    g_exp = '{0, 50, 100, 150, 200, 120, 40, 40};
    run_line("backpressure", 'h080, 4, 8, 3, 1'b1, 1'b0);
    bp_mode = 1'b0;

    g_src = '{0, 1};
`ifdef HSCALE_ROUND_EN
    g_exp = '{0, 1};
`else
    g_exp = '{0, 0};
`endif
    run_line("round", 'h080, 2, 2, 1, 1'b0, 1'b0);

    g_src = '{10, 20, 30};
    g_exp = '{10, 20, 30, 30, 30, 30};
    run_line("early_eol", 'h100, 6, 6, 2, 1'b0, 1'b1);

    // Abort a line part way through; the sticky error must clear as well.
    mon_en = 1'b0;
    @(posedge clk);
    #1;
    cfg_step      = 12'h100;
    cfg_src_width = 11'd8;
    cfg_tgt_width = 11'd8;
    for (int k = 0; k < 5; k++) begin
      in_data  = pack(k * 5);
      in_valid = 1'b1;
      in_eol   = 1'b0;
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    chk_reset_vals("midline_rst");
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    mon_en = 1'b1;
    @(negedge clk);
    chk("post_rst_idle_ready", 32'(in_ready), 32'd1);

    g_src = '{0, 100, 200, 40};
    g_exp = '{0, 50, 100, 150, 200, 120, 40, 40};
    run_line("after_rst", 'h080, 4, 8, 3, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
